// File: rtl/imm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imm_pkg
// Description : Shared opcodes, immediate format codes and the decoded
//               immediate record used by the immediate-decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
package imm_pkg;

    // Base-ISA major opcodes (instr[6:0])
    localparam logic [6:0] c_opc_load     = 7'b0000011;
    localparam logic [6:0] c_opc_misc_mem = 7'b0001111;
    localparam logic [6:0] c_opc_op_imm   = 7'b0010011;
    localparam logic [6:0] c_opc_auipc    = 7'b0010111;
    localparam logic [6:0] c_opc_store    = 7'b0100011;
    localparam logic [6:0] c_opc_op       = 7'b0110011;
    localparam logic [6:0] c_opc_lui      = 7'b0110111;
    localparam logic [6:0] c_opc_branch   = 7'b1100011;
    localparam logic [6:0] c_opc_jalr     = 7'b1100111;
    localparam logic [6:0] c_opc_jal      = 7'b1101111;
    localparam logic [6:0] c_opc_system   = 7'b1110011;

    // Widest supported datapath; narrower stages keep the low bits
    localparam int c_imm_w = 64;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_SH   = 3'd2,
        FMT_S    = 3'd3,
        FMT_B    = 3'd4,
        FMT_U    = 3'd5,
        FMT_J    = 3'd6,
        FMT_NONE = 3'd7
    } imm_fmt_e;

    typedef struct packed {
        logic [c_imm_w-1:0] imm;
        imm_fmt_e           fmt;
        logic               illegal;
    } imm_dec_t;

    // All base immediates fit in 32 bits; widen keeping the sign
    function automatic logic [c_imm_w-1:0] sext32(input logic [31:0] v);
        return {{(c_imm_w-32){v[31]}}, v};
    endfunction

endpackage
`default_nettype wire

// File: rtl/imm_extract.sv
`default_nettype none
// ============================================================================
// Module      : imm_extract
// Description : Combinational immediate extraction for RV32I/RV64I base
//               formats; produces immediate, format code and illegal flag.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_extract
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0] instr,
    output imm_dec_t    dec
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [5:0] w_shamt;

    assign w_opcode = instr[6:0];
    assign w_funct3 = instr[14:12];
    // RV64 shifts use a 6-bit shamt; RV32 only 5 bits
    assign w_shamt  = (XLEN == 64) ? instr[25:20] : {1'b0, instr[24:20]};

    // Select the immediate layout from the major opcode
    always_comb begin
        dec.imm     = '0;
        dec.fmt     = FMT_NONE;
        dec.illegal = 1'b1;
        if (instr[1:0] == 2'b11) begin
            dec.illegal = 1'b0;
            case (w_opcode)
                c_opc_load, c_opc_jalr, c_opc_system: begin
                    dec.imm = sext32({{20{instr[31]}}, instr[31:20]});
                    dec.fmt = FMT_I;
                end
                c_opc_op_imm: begin
                    if (w_funct3 == 3'b001 || w_funct3 == 3'b101) begin
                        dec.imm = {{(c_imm_w-6){1'b0}}, w_shamt};
                        dec.fmt = FMT_SH;
                    end else begin
                        dec.imm = sext32({{20{instr[31]}}, instr[31:20]});
                        dec.fmt = FMT_I;
                    end
                end
                c_opc_store: begin
                    dec.imm = sext32({{20{instr[31]}}, instr[31:25], instr[11:7]});
                    dec.fmt = FMT_S;
                end
                c_opc_branch: begin
                    dec.imm = sext32({{19{instr[31]}}, instr[31], instr[7],
                                      instr[30:25], instr[11:8], 1'b0});
                    dec.fmt = FMT_B;
                end
                c_opc_lui, c_opc_auipc: begin
                    dec.imm = sext32({instr[31:12], 12'b0});
                    dec.fmt = FMT_U;
                end
                c_opc_jal: begin
                    dec.imm = sext32({{11{instr[31]}}, instr[31], instr[19:12],
                                      instr[20], instr[30:21], 1'b0});
                    dec.fmt = FMT_J;
                end
                c_opc_op, c_opc_misc_mem: begin
                    dec.fmt = FMT_R;
                end
                default: begin
                    dec.fmt     = FMT_NONE;
                    dec.illegal = 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/imm_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : imm_decode_stage
// Description : Registered immediate-decode pipeline stage with a two-entry
//               skid buffer (main + skid) behind a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    imm_dec_t        w_dec;
    logic [XLEN-1:0] w_in_imm;

    imm_extract #(.XLEN(XLEN)) u_imm_extract (
        .instr (in_instr),
        .dec   (w_dec)
    );

    assign w_in_imm = w_dec.imm[XLEN-1:0];

    // Upper immediate bits only exist for the widest datapath
    if (XLEN < c_imm_w) begin : g_trunc
        logic w_unused_imm_hi;
        assign w_unused_imm_hi = ^w_dec.imm[c_imm_w-1:XLEN];
    end

    logic            r_main_valid, r_skid_valid, r_in_ready;
    logic [31:0]     r_main_instr, r_skid_instr;
    logic [XLEN-1:0] r_main_pc,    r_skid_pc;
    logic [XLEN-1:0] r_main_imm,   r_skid_imm;
    imm_fmt_e        r_main_fmt,   r_skid_fmt;
    logic            r_main_ill,   r_skid_ill;

    logic w_in_fire, w_out_fire;
    logic w_load_main_in, w_load_main_skid, w_load_skid;
    logic w_main_valid_n, w_skid_valid_n;

    assign w_in_fire  = in_valid & r_in_ready;
    assign w_out_fire = r_main_valid & out_ready;

    // Skid-buffer transitions; state is encoded by the two valid bits
    always_comb begin
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        w_main_valid_n   = r_main_valid;
        w_skid_valid_n   = r_skid_valid;
        if (flush) begin
            w_main_valid_n = 1'b0;
            w_skid_valid_n = 1'b0;
        end else if (r_skid_valid) begin
            if (w_out_fire) begin
                w_load_main_skid = 1'b1;
                w_skid_valid_n   = 1'b0;
            end
        end else if (r_main_valid) begin
            if (w_in_fire && w_out_fire) begin
                w_load_main_in = 1'b1;
            end else if (w_in_fire) begin
                w_load_skid    = 1'b1;
                w_skid_valid_n = 1'b1;
            end else if (w_out_fire) begin
                w_main_valid_n = 1'b0;
            end
        end else if (w_in_fire) begin
            w_load_main_in = 1'b1;
            w_main_valid_n = 1'b1;
        end
    end

    // Valid bits and the registered ready, cleared immediately on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else begin
            r_main_valid <= w_main_valid_n;
            r_skid_valid <= w_skid_valid_n;
            r_in_ready   <= ~w_skid_valid_n;
        end
    end

    // Main register payload: loads from the input or drains the skid entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_instr <= '0;
            r_main_pc    <= '0;
            r_main_imm   <= '0;
            r_main_fmt   <= FMT_R;
            r_main_ill   <= 1'b0;
        end else if (w_load_main_in) begin
            r_main_instr <= in_instr;
            r_main_pc    <= in_pc;
            r_main_imm   <= w_in_imm;
            r_main_fmt   <= w_dec.fmt;
            r_main_ill   <= w_dec.illegal;
        end else if (w_load_main_skid) begin
            r_main_instr <= r_skid_instr;
            r_main_pc    <= r_skid_pc;
            r_main_imm   <= r_skid_imm;
            r_main_fmt   <= r_skid_fmt;
            r_main_ill   <= r_skid_ill;
        end
    end

    // Skid register payload: captures the one extra accept after a stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skid_instr <= '0;
            r_skid_pc    <= '0;
            r_skid_imm   <= '0;
            r_skid_fmt   <= FMT_R;
            r_skid_ill   <= 1'b0;
        end else if (w_load_skid) begin
            r_skid_instr <= in_instr;
            r_skid_pc    <= in_pc;
            r_skid_imm   <= w_in_imm;
            r_skid_fmt   <= w_dec.fmt;
            r_skid_ill   <= w_dec.illegal;
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_main_valid;
    assign out_instr   = r_main_instr;
    assign out_pc      = r_main_pc;
    assign out_imm     = r_main_imm;
    assign out_fmt     = r_main_fmt;
    assign out_illegal = r_main_ill;

endmodule
`default_nettype wire

// File: tb/tb_imm_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_decode_stage
// Description : Self-checking bench; drives a 32-bit and a 64-bit instance
//               with the same stream and scoreboards every emitted result.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;

    logic        in_ready32, out_valid32, out_ill32;
    logic [31:0] out_instr32, out_pc32, out_imm32;
    logic [2:0]  out_fmt32;
    logic        in_ready64, out_valid64, out_ill64;
    logic [31:0] out_instr64;
    logic [63:0] out_pc64, out_imm64;
    logic [2:0]  out_fmt64;

    always #5 clk = ~clk;

    imm_decode_stage #(.XLEN(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32),
        .in_instr(in_instr), .in_pc(in_pc[31:0]),
        .out_valid(out_valid32), .out_ready(out_ready),
        .out_instr(out_instr32), .out_pc(out_pc32), .out_imm(out_imm32),
        .out_fmt(out_fmt32), .out_illegal(out_ill32)
    );

    imm_decode_stage #(.XLEN(64)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid64), .out_ready(out_ready),
        .out_instr(out_instr64), .out_pc(out_pc64), .out_imm(out_imm64),
        .out_fmt(out_fmt64), .out_illegal(out_ill64)
    );

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [31:0] imm32;
        logic [63:0] imm64;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    // Directed vectors: instruction, expected imm (XLEN 32 / 64), fmt, illegal
    // fmt: R0 I1 SH2 S3 B4 U5 J6 NONE7
    logic [31:0] t_instr [18] = '{
        32'hFFF18093, 32'hFE000EE3, 32'h001000EF, 32'h01F0D093, 32'h800000B7,
        32'h03F09093, 32'h0000007F, 32'h00000000, 32'hFE20AC23, 32'h002081B3,
        32'h7FF080E7, 32'h12345097, 32'h0FF0000F, 32'h00000073, 32'h4010D093,
        32'hFFF18090, 32'h00208463, 32'hFFDFF0EF};
    logic [31:0] t_imm32 [18] = '{
        32'hFFFFFFFF, 32'hFFFFFFFC, 32'h00000800, 32'h0000001F, 32'h80000000,
        32'h0000001F, 32'h00000000, 32'h00000000, 32'hFFFFFFF8, 32'h00000000,
        32'h000007FF, 32'h12345000, 32'h00000000, 32'h00000000, 32'h00000001,
        32'h00000000, 32'h00000008, 32'hFFFFFFFC};
    logic [63:0] t_imm64 [18] = '{
        64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'h0000000000000800,
        64'h000000000000001F, 64'hFFFFFFFF80000000, 64'h000000000000003F,
        64'h0, 64'h0, 64'hFFFFFFFFFFFFFFF8, 64'h0, 64'h00000000000007FF,
        64'h0000000012345000, 64'h0, 64'h0, 64'h0000000000000001, 64'h0,
        64'h0000000000000008, 64'hFFFFFFFFFFFFFFFC};
    logic [2:0]  t_fmt [18] = '{
        3'd1, 3'd4, 3'd6, 3'd2, 3'd5, 3'd2, 3'd7, 3'd7, 3'd3,
        3'd0, 3'd1, 3'd5, 3'd0, 3'd1, 3'd2, 3'd7, 3'd4, 3'd6};
    logic        t_ill [18] = '{
        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    exp_t sb[$];
    exp_t cur;
    exp_t e;
    int   n_checks = 0;
    int   n_err    = 0;
    int   n_out    = 0;
    int   n_mark;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int idx, input logic [63:0] pc);
        in_valid  = 1'b1;
        in_instr  = t_instr[idx];
        in_pc     = pc;
        cur.instr = t_instr[idx];
        cur.pc    = pc;
        cur.imm32 = t_imm32[idx];
        cur.imm64 = t_imm64[idx];
        cur.fmt   = t_fmt[idx];
        cur.ill   = t_ill[idx];
    endtask

    // Scoreboard: pop on each output transfer, push on each accepted input
    always @(negedge clk) begin
        if (!rst_n || flush) begin
            sb.delete();
        end else begin
            if (out_valid32 && out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", {63'd0, out_valid32}, 64'd0);
                end else begin
                    e = sb.pop_front();
                    n_out++;
                    chk("valid64", {63'd0, out_valid64}, 64'd1);
                    chk("instr32", {32'd0, out_instr32}, {32'd0, e.instr});
                    chk("instr64", {32'd0, out_instr64}, {32'd0, e.instr});
                    chk("pc32",    {32'd0, out_pc32},    {32'd0, e.pc[31:0]});
                    chk("pc64",    out_pc64,             e.pc);
                    chk("imm32",   {32'd0, out_imm32},   {32'd0, e.imm32});
                    chk("imm64",   out_imm64,            e.imm64);
                    chk("fmt32",   {61'd0, out_fmt32},   {61'd0, e.fmt});
                    chk("fmt64",   {61'd0, out_fmt64},   {61'd0, e.fmt});
                    chk("ill32",   {63'd0, out_ill32},   {63'd0, e.ill});
                    chk("ill64",   {63'd0, out_ill64},   {63'd0, e.ill});
                end
            end
            if (in_valid && in_ready32) sb.push_back(cur);
        end
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        set_in(0, 64'hFFFF_0000_8000_0000);
        repeat (3) cycle();

        // Reset state while in_valid is held high
        chk("rst_out_valid32", {63'd0, out_valid32}, 64'd0);
        chk("rst_out_valid64", {63'd0, out_valid64}, 64'd0);
        chk("rst_in_ready32",  {63'd0, in_ready32},  64'd1);
        chk("rst_in_ready64",  {63'd0, in_ready64},  64'd1);
        chk("rst_imm32",       {32'd0, out_imm32},   64'd0);
        chk("rst_imm64",       out_imm64,            64'd0);
        chk("rst_instr",       {32'd0, out_instr32}, 64'd0);
        chk("rst_pc64",        out_pc64,             64'd0);
        chk("rst_fmt",         {61'd0, out_fmt32},   64'd0);
        chk("rst_ill",         {63'd0, out_ill32},   64'd0);

        // First accept one cycle after release, then full-rate stream
        rst_n  = 1'b1;
        n_mark = n_out;
        chk("pre_accept", {63'd0, out_valid32}, 64'd0);
        cycle();
        chk("first_accept32", {63'd0, out_valid32}, 64'd1);
        chk("first_accept64", {63'd0, out_valid64}, 64'd1);
        for (int i = 1; i < 18; i++) begin
            set_in(i, 64'hFFFF_0000_8000_0000 + 64'(i * 4));
            chk("stream_ready", {63'd0, in_ready32}, 64'd1);
            cycle();
        end
        in_valid = 1'b0;
        repeat (2) cycle();
        chk("stream_count", 64'(n_out - n_mark), 64'd18);
        chk("stream_drained", {63'd0, out_valid32}, 64'd0);

        // Backpressure: A, B accepted, C held off until downstream resumes
        out_ready = 1'b0;
        n_mark    = n_out;
        set_in(4, 64'h0000_0001_0000_1000);
        cycle();
        chk("bp_ready_one", {63'd0, in_ready32}, 64'd1);
        set_in(5, 64'h0000_0001_0000_1004);
        cycle();
        chk("bp_ready_low32", {63'd0, in_ready32}, 64'd0);
        chk("bp_ready_low64", {63'd0, in_ready64}, 64'd0);
        chk("bp_hold_instr", {32'd0, out_instr32}, {32'd0, t_instr[4]});
        set_in(6, 64'h0000_0001_0000_1008);
        cycle();
        chk("bp_still_low", {63'd0, in_ready32}, 64'd0);
        chk("bp_hold_valid", {63'd0, out_valid32}, 64'd1);
        chk("bp_hold_imm64", out_imm64, t_imm64[4]);
        cycle();
        chk("bp_hold_pc64", out_pc64, 64'h0000_0001_0000_1000);
        out_ready = 1'b1;
        cycle();
        chk("bp_reopen", {63'd0, in_ready32}, 64'd1);
        cycle();
        in_valid = 1'b0;
        repeat (2) cycle();
        chk("bp_count", 64'(n_out - n_mark), 64'd3);

        // Flush while full, with a new instruction offered in the same cycle
        out_ready = 1'b0;
        set_in(8, 64'h0000_0002_0000_0000);
        cycle();
        set_in(9, 64'h0000_0002_0000_0004);
        cycle();
        chk("fl_two_ready", {63'd0, in_ready32}, 64'd0);
        set_in(10, 64'h0000_0002_0000_0008);
        flush = 1'b1;
        cycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid32", {63'd0, out_valid32}, 64'd0);
        chk("fl_valid64", {63'd0, out_valid64}, 64'd0);
        chk("fl_ready32", {63'd0, in_ready32},  64'd1);
        chk("fl_ready64", {63'd0, in_ready64},  64'd1);
        out_ready = 1'b1;
        n_mark    = n_out;
        repeat (3) cycle();
        chk("fl_no_out", 64'(n_out - n_mark), 64'd0);
        set_in(11, 64'h0000_0002_0000_0010);
        cycle();
        in_valid = 1'b0;
        repeat (2) cycle();
        chk("post_flush_count", 64'(n_out - n_mark), 64'd1);

        // Reset mid-operation clears contents immediately
        set_in(2, 64'h0000_0003_0000_0000);
        cycle();
        in_valid = 1'b0;
        chk("mr_loaded", {63'd0, out_valid32}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mr_async_valid", {63'd0, out_valid32}, 64'd0);
        chk("mr_async_imm",   out_imm64,            64'd0);
        cycle();
        rst_n  = 1'b1;
        n_mark = n_out;
        repeat (2) cycle();
        chk("mr_no_partial", {63'd0, out_valid32}, 64'd0);
        chk("mr_no_out", 64'(n_out - n_mark), 64'd0);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
